// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// pipeline_hazard_ctrl_if: hazard inputs and IF/ID sequencing outputs of the hazard controller.
// Rev 1.0
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             ex_branch_taken;
  logic             im_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] redirect_count;

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken, im_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, ctrl_state,
           stall_cycles, redirect_count
  );

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken, im_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ctrl_state,
           stall_cycles, redirect_count
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// pipeline_hazard_ctrl: PC / IF_ID / ID_EX sequencing for load-use, taken branch and I-mem wait.
// Optional statistics counters built when PIPE_CTRL_STATS_EN is defined. Rev 1.0
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  wire logic            clock,
  input  wire logic            reset_n,
  pipeline_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    IM_WAIT  = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   load_use;
  logic   pc_write, if_id_write, if_id_flush, id_ex_bubble;

  assign load_use = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    state_nxt    = RUN;
    if (!reset_n) begin
      pc_write     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      case (state)
        RUN, IM_WAIT: begin
          if (bus.ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_nxt    = REDIRECT;
          end else if ((state == RUN) && load_use) begin
            // IF_ID holds; the bubble in ID/EX clears the hazard next cycle
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (!bus.im_ready) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            state_nxt   = IM_WAIT;
          end
        end
        REDIRECT: begin
          if (!bus.im_ready) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            state_nxt   = IM_WAIT;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    state <= state_nxt;
  end

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.ctrl_state   = state;

`ifdef PIPE_CTRL_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  logic             branch_accepted;
  logic [CNT_W-1:0] stall_cnt, redirect_cnt;

  assign branch_accepted = bus.ex_branch_taken && ((state == RUN) || (state == IM_WAIT));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + 1'b1;
      if (branch_accepted && (redirect_cnt != CNT_MAX))
        redirect_cnt <= redirect_cnt + 1'b1;
    end
  end

  assign bus.stall_cycles   = stall_cnt;
  assign bus.redirect_count = redirect_cnt;
`else
  assign bus.stall_cycles   = '0;
  assign bus.redirect_count = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// tb_pipeline_hazard_ctrl: directed vector table, hand sequences and random stimulus vs. a reference model.
// Rev 1.0
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();
  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  typedef struct {
    bit       rst_n;
    bit       br;
    bit       mr;
    bit [4:0] ex_rt;
    bit [4:0] rs;
    bit [4:0] rt;
    bit       urt;
    bit       imr;
    bit [3:0] exp_out;   // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
    int       exp_state;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 running, 1 waiting on memory, 2 the slot after a redirect
  int m_mode, m_stall, m_redir;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic step(input vec_t v, input bit use_tbl);
    bit       lu, br_ok;
    bit [3:0] m_out, got;
    int       nxt;
    @(negedge clock);
    reset_n            = v.rst_n;
    bus.ex_branch_taken = v.br;
    bus.ex_mem_read    = v.mr;
    bus.ex_rt          = v.ex_rt;
    bus.id_rs          = v.rs;
    bus.id_rt          = v.rt;
    bus.id_uses_rt     = v.urt;
    bus.im_ready       = v.imr;
    #1;
    lu    = v.mr && v.ex_rt != 0 && (v.ex_rt == v.rs || (v.urt && v.ex_rt == v.rt));
    br_ok = v.br && m_mode != 2;
    if (!v.rst_n)                   begin m_out = 4'b0111; nxt = 0; end
    else if (br_ok)                 begin m_out = 4'b1111; nxt = 2; end
    else if (m_mode == 0 && lu)     begin m_out = 4'b0001; nxt = 0; end
    else if (!v.imr)                begin m_out = 4'b0110; nxt = 1; end
    else                            begin m_out = 4'b1100; nxt = 0; end
    got = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble};
    check("outputs", int'(got), int'(m_out));
    check("ctrl_state", int'(bus.ctrl_state), m_mode);
`ifdef PIPE_CTRL_STATS_EN
    check("stall_cycles", int'(bus.stall_cycles), m_stall);
    check("redirect_count", int'(bus.redirect_count), m_redir);
`else
    check("stall_cycles", int'(bus.stall_cycles), 0);
    check("redirect_count", int'(bus.redirect_count), 0);
`endif
    if (use_tbl) begin
      check("tbl_outputs", int'(got), int'(v.exp_out));
      check("tbl_state", int'(bus.ctrl_state), v.exp_state);
    end
    if (!v.rst_n) begin
      m_stall = 0;
      m_redir = 0;
    end else begin
      if (!m_out[3] && m_stall < CMAX) m_stall++;
      if (br_ok && m_redir < CMAX) m_redir++;
    end
    m_mode = nxt;
  endtask

  function automatic vec_t mk(bit rst_n, bit br, bit mr, bit [4:0] ex_rt, bit [4:0] rs,
                              bit [4:0] rt, bit urt, bit imr, bit [3:0] eo, int es);
    vec_t v;
    v.rst_n = rst_n; v.br = br; v.mr = mr; v.ex_rt = ex_rt; v.rs = rs; v.rt = rt;
    v.urt = urt; v.imr = imr; v.exp_out = eo; v.exp_state = es;
    return v;
  endfunction

  function automatic vec_t idle(bit imr);
    return mk(1, 0, 0, 0, 0, 0, 0, imr, 4'b0, 0);
  endfunction

  vec_t tbl[$];
  vec_t v;
  int   expect_cnt;

  initial begin
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 4'b0111, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 4'b0111, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 4'b0111, 0));
    tbl.push_back(mk(1,0,0,0,0,0,0,1, 4'b1100, 0));
    tbl.push_back(mk(1,0,1,8,8,0,0,1, 4'b0001, 0));  // load-use on rs
    tbl.push_back(mk(1,0,0,0,8,0,0,1, 4'b1100, 0));
    tbl.push_back(mk(1,0,1,0,0,0,1,1, 4'b1100, 0));  // $zero never hazards
    tbl.push_back(mk(1,0,1,9,1,9,0,1, 4'b1100, 0));  // rt not a source
    tbl.push_back(mk(1,0,1,9,1,9,1,1, 4'b0001, 0));  // load-use on rt
    tbl.push_back(mk(1,1,0,0,0,0,0,1, 4'b1111, 0));  // taken branch
    tbl.push_back(mk(1,0,0,0,0,0,0,1, 4'b1100, 2));
    tbl.push_back(mk(1,0,0,0,0,0,0,1, 4'b1100, 0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 4'b0110, 0));  // memory wait x4
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 4'b0110, 1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 4'b0110, 1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 4'b0110, 1));
    tbl.push_back(mk(1,0,0,0,0,0,0,1, 4'b1100, 1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 4'b0110, 0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 4'b0110, 1));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 4'b1111, 1));  // branch during wait
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 4'b0110, 2));  // branch ignored in redirect slot
    tbl.push_back(mk(1,0,0,0,0,0,0,1, 4'b1100, 1));
    tbl.push_back(mk(1,1,1,3,3,0,0,1, 4'b1111, 0));  // branch beats load-use
    tbl.push_back(mk(1,0,0,0,0,0,0,1, 4'b1100, 2));
    tbl.push_back(mk(1,0,1,4,4,0,0,0, 4'b0001, 0));  // load-use beats wait
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 4'b0110, 0));
    tbl.push_back(mk(1,0,0,0,0,0,0,1, 4'b1100, 1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 4'b0110, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 4'b0111, 1));  // reset mid-wait
    tbl.push_back(mk(1,0,0,0,0,0,0,1, 4'b1100, 0));

    reset_n = 1'b0;
    bus.ex_branch_taken = 0; bus.ex_mem_read = 0; bus.ex_rt = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 0; bus.im_ready = 1;
    @(posedge clock);
    m_mode = 0; m_stall = 0; m_redir = 0;

    foreach (tbl[i]) step(tbl[i], 1'b1);

    // Memory wait of 4 cycles counts 4 stalls
    step(mk(0,0,0,0,0,0,0,1, 4'b0, 0), 1'b0);
    for (int i = 0; i < 4; i++) step(idle(0), 1'b0);
    step(idle(1), 1'b0);
`ifdef PIPE_CTRL_STATS_EN
    expect_cnt = 4;
`else
    expect_cnt = 0;
`endif
    check("stall_after_wait4", int'(bus.stall_cycles), expect_cnt);

    // Saturation: 20 wait cycles on a 4-bit counter
    step(mk(0,0,0,0,0,0,0,1, 4'b0, 0), 1'b0);
    for (int i = 0; i < 20; i++) step(idle(0), 1'b0);
    step(idle(1), 1'b0);
`ifdef PIPE_CTRL_STATS_EN
    expect_cnt = CMAX;
`else
    expect_cnt = 0;
`endif
    check("stall_saturated", int'(bus.stall_cycles), expect_cnt);

    for (int i = 0; i < 500; i++) begin
      v = mk(($urandom_range(0, 29) != 0), ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom_range(0, 1), ($urandom_range(0, 3) != 0), 4'b0, 0);
      step(v, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequencing controller for the IF stage and the IF_ID pipeline register of the multistage datapath. Each cycle it decides whether the PC advances and whether IF_ID captures, holds, or is loaded with a NOP. It also decides whether the ID/EX stage receives a bubble. It resolves three events: load-use hazards, taken branches/jumps resolved in EX, and instruction-memory wait states. An optional statistics block counts stall cycles and redirects.

## Interface
- CNT_W, 16, width of each statistics counter

- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- id_rs  in  5  rs field of the instruction currently in IF_ID
- id_rt  in  5  rt field of the instruction currently in IF_ID
- id_uses_rt  in  1  the ID instruction reads rt as a source
- ex_mem_read  in  1  the instruction in ID/EX is a load
- ex_rt  in  5  destination register of that load
- ex_branch_taken  in  1  branch/jump in EX resolved taken; PC mux selects target
- im_ready  in  1  im_out is valid this cycle
- pc_write  out  1  PC register load enable
- if_id_write  out  1  IF_ID load enable
- if_id_flush  out  1  IF_ID loads 32'h0 (NOP) instead of im_out; only meaningful with if_id_write=1
- id_ex_bubble  out  1  ID/EX control fields zeroed
- ctrl_state  out  2  current FSM state
- stall_cycles  out  CNT_W  cycles with pc_write=0
- redirect_count  out  CNT_W  accepted taken branches

## Operation
- Outputs are combinational from the state register and the inputs (Mealy). The state register and counters update on posedge clock.
- While reset_n=0, outputs are forced: pc_write=0, if_id_write=1, if_id_flush=1, id_ex_bubble=1. The state goes to RUN and the counters clear.
- Load-use hazard `lu` = ex_mem_read & (ex_rt≠0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- "Normal" outputs: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
- States: RUN=2'd0, IM_WAIT=2'd1, REDIRECT=2'd2. Encoding 2'd3 is illegal and recovers to RUN with normal outputs.
- RUN. Conditions are evaluated in priority order:
  1. ex_branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1. Next state REDIRECT.
  2. lu: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1. Next state RUN. This is a one-cycle stall; it clears naturally because ID/EX then holds the bubble.
  3. !im_ready: pc_write=0, if_id_write=1, if_id_flush=1, id_ex_bubble=0. Next state IM_WAIT.
  4. Otherwise: normal outputs. Next state RUN.
- IM_WAIT. IF_ID holds a NOP, so lu cannot occur. Older instructions keep draining.
  - ex_branch_taken: same outputs as RUN case 1. Next state REDIRECT. The pending fetch is abandoned.
  - !im_ready: pc_write=0, if_id_write=1, if_id_flush=1, id_ex_bubble=0. Stay in IM_WAIT.
  - im_ready: normal outputs. Next state RUN.
- REDIRECT. Lasts one cycle after a taken branch. ex_branch_taken is ignored because EX holds a bubble.
  - im_ready: normal outputs. Next state RUN.
  - !im_ready: same outputs as RUN case 3. Next state IM_WAIT.

## Timing
- Load-use penalty is exactly 1 cycle.
- Taken-branch penalty is 2 squashed slots: IF_ID is flushed and ID/EX is bubbled in the resolve cycle. The target instruction reaches IF_ID one cycle later if im_ready=1.
- Memory wait adds one cycle per im_ready=0 cycle. The first valid fetch is captured in the same cycle im_ready rises.
- Simultaneous branch and lu: the branch wins and no stall is counted.
- Simultaneous lu and !im_ready in RUN: lu wins. im_ready is re-evaluated in the next cycle.
- Reset asserted mid-operation takes effect at the next posedge. No state survives reset.

## Configuration
- PIPE_CTRL_STATS_EN defined:
  - stall_cycles increments every non-reset cycle with pc_write=0.
  - redirect_count increments every cycle with ex_branch_taken accepted (RUN or IM_WAIT).
  - Both counters saturate at 2^CNT_W−1 and clear on reset.
- PIPE_CTRL_STATS_EN undefined: no counter logic is built. stall_cycles and redirect_count are tied to 0. The ports remain in place.

## Test plan
- Reset: hold reset_n=0 for 3 cycles → pc_write=0, if_id_flush=1, id_ex_bubble=1, ctrl_state=0, counters 0. Release with no hazards → normal outputs next cycle.
- Load-use: ex_mem_read=1, ex_rt=5'd8, id_rs=5'd8 → exactly one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1. Repeat with ex_rt=0 → no stall. Repeat with ex_rt==id_rt and id_uses_rt=0 → no stall.
- Taken branch in RUN: ex_branch_taken=1 for 1 cycle with im_ready=1 → flush+bubble that cycle, ctrl_state=2 the next cycle, then back to 0. redirect_count=1 with PIPE_CTRL_STATS_EN.
- Memory wait: im_ready low for 4 cycles → ctrl_state=1 for those cycles with pc_write=0 and if_id_flush=1. Resume on im_ready=1. stall_cycles=4.
- Branch during IM_WAIT: im_ready=0 for 2 cycles, then ex_branch_taken=1 → pc_write=1, flush+bubble, ctrl_state=2 next.
- Priority and saturation: assert ex_branch_taken and lu together → branch outputs, stall_cycles unchanged. With CNT_W=4, hold im_ready=0 for 20 cycles → stall_cycles stops at 15.
